draw_port_arbiter: RTL and testbench
====================================

Name: draw_port_arbiter

Overview:
- Shares the single 160x120 pixel-write port of the VGA adapter among NUM_REQ sprite requesters, e.g. player cursor, bird and score marker.
- Each requester asks for a SPR_W x SPR_H solid rectangle at a given origin and colour.
- The arbiter grants requesters round-robin and scans the rectangle one pixel per clock onto x_out/y_out/colour_out/plot.
- It pulses done to the granted requester when the rectangle is finished.
- It sits between the movement/bird FSMs and the VGA adapter, replacing direct datapath-to-adapter wiring.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- SPR_W, 4, rectangle width in pixels (1..16).
- SPR_H, 4, rectangle height in pixels (1..16).
- BG_COLOUR, 3'b000, erase colour; used only when the optional erase feature is compiled in.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  level request; requester holds it high until its done pulse.
- req_x  in  8*NUM_REQ  origin X per requester, flattened; requester i uses bits [8i+7:8i].
- req_y  in  7*NUM_REQ  origin Y per requester, flattened.
- req_colour  in  3*NUM_REQ  fill colour per requester.
- grant  out  NUM_REQ  one-hot; high for the whole service of the granted requester.
- done  out  NUM_REQ  one-cycle pulse to the served requester.
- busy  out  1  high whenever the state is not IDLE.
- x_out  out  8  pixel X to the adapter.
- y_out  out  7  pixel Y to the adapter.
- colour_out  out  3  pixel colour to the adapter.
- plot  out  1  adapter write enable.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - All state changes on the rising edge of clk.
  - reset_n is sampled only at the clock edge.
- Reset values:
  - grant, done, busy, plot: 0.
  - x_out, y_out, colour_out: 0.
  - State IDLE, round-robin pointer 0, row/col counters 0.
- Reset mid-operation: the current rectangle is abandoned, no done pulse is issued, and all of the above values apply on the next edge.
- States: IDLE, DRAW, DONE; plus ERASE when ERASE_EN is defined.
- IDLE:
  - If any req bit is high, select the winner: the first set bit at or after the pointer, scanning upward with wrap.
  - Latch the winner's x, y and colour.
  - Assert grant[winner] and go to DRAW.
  - If no req bit is high, stay in IDLE with plot = 0.
- DRAW:
  - Every cycle presents pixel (x0+col, y0+row) with the latched colour.
  - col is the inner loop (0..SPR_W-1), row the outer loop (0..SPR_H-1).
  - Lasts exactly SPR_W*SPR_H cycles, then goes to DONE.
- DONE:
  - One cycle: done[winner] = 1 and grant drops.
  - Pointer becomes (winner+1) mod NUM_REQ.
  - Next state is IDLE.
- Latency:
  - req high in IDLE at edge N gives first plot at cycle N+1 and last plot at N+SPR_W*SPR_H.
  - done pulses at N+SPR_W*SPR_H+1.
  - The earliest next grant is at N+SPR_W*SPR_H+2.
- Clipping:
  - Pixel sums use 9-bit X and 8-bit Y.
  - A pixel with X >= 160 or Y >= 120 has plot = 0 but still consumes its cycle, so no wrap-around draws at column 0.
- Request changes during service:
  - Inputs are latched at grant; changes during DRAW are ignored.
  - If req is dropped mid-draw, the rectangle still completes and done still pulses.
- Simultaneous requests: exactly one grant at a time. Fairness: with all requesters constantly asserting, grants rotate 0,1,2,0,...
- plot is high only in DRAW/ERASE cycles with on-screen pixels.
- x_out and y_out are registered outputs and need not be held at any particular value while plot = 0.

Optional Feature:
- Macro: DRAW_ARB_ERASE_EN.
- When defined:
  - Each requester has a stored last-drawn origin plus a valid bit, all cleared by reset.
  - On grant with valid = 1, the arbiter first runs ERASE: SPR_W*SPR_H cycles painting BG_COLOUR at the stored origin, with the same scan order and clipping as DRAW.
  - It then runs DRAW, then DONE.
  - On DONE, the stored origin is updated to the latched origin and valid is set.
  - Latency grows by SPR_W*SPR_H cycles whenever valid is set.
- When not defined: no storage, and IDLE goes directly to DRAW.

Decomposition:
- Shared package draw_pkg:
  - Constants SCREEN_W = 160, SCREEN_H = 120, COLOUR_W = 3, X_W = 8, Y_W = 7.
  - State encoding for IDLE/ERASE/DRAW/DONE.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req vector, pointer.
  - Output: one-hot winner.
  - Purely combinational; the pointer register is owned by the parent.

Test Plan:
- Single request: req[1] with x=10, y=20, colour=3'b100 → 16 plot cycles covering (10..13, 20..23) row-major, then done[1] one cycle after the last plot; total 18 cycles from req to IDLE.
- Contention: req = 3'b111 held high → grant order 0, 1, 2, 0 with no overlapping grants.
- Pointer advance: req[0] is served, then req[0] and req[2] are asserted together → req[2] wins.
- Clipping: req[0] at x=158, y=118 → exactly 4 plots (158..159, 118..119), 16 DRAW cycles, done still pulses.
- Reset mid-draw: reset_n = 0 at the 5th DRAW cycle → next cycle plot = 0, grant = 0, busy = 0, no done pulse; with req still high, service restarts from pixel 0.
- With DRAW_ARB_ERASE_EN: req[1] at (10,20), then again at (30,40) → the second service first paints 16 pixels of 3'b000 at (10..13, 20..23), then 16 pixels at (30..33, 40..43), and done arrives 33 cycles after the grant.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared constants, FSM state encoding and pixel helper for the VGA draw-port arbiter.
package draw_pkg;

  localparam logic [8:0] SCREEN_W = 9'd160;
  localparam logic [7:0] SCREEN_H = 8'd120;
  localparam int COLOUR_W = 3;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERASE = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic           plot;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pix_t;

  // Sums are one bit wider than the screen coordinates so off-screen pixels
  // are suppressed instead of wrapping back onto column/row 0.
  function automatic pix_t make_pix(input logic [X_W-1:0] ox, input logic [Y_W-1:0] oy,
                                    input logic [3:0] col, input logic [3:0] row);
    logic [X_W:0] sx;
    logic [Y_W:0] sy;
    pix_t         p;
    sx     = {1'b0, ox} + {5'b0, col};
    sy     = {1'b0, oy} + {4'b0, row};
    p.plot = (sx < SCREEN_W) && (sy < SCREEN_H);
    p.x    = sx[X_W-1:0];
    p.y    = sy[Y_W-1:0];
    return p;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping upward.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_grant
);

  localparam int PW = $clog2(N);
  localparam logic [PW:0] N_W = (PW+1)'(N);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_sum >= N_W) w_sum = w_sum - N_W;
      w_idx = w_sum[PW-1:0];
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_port_arbiter.sv
// Round-robin sharing of the VGA pixel-write port among sprite requesters, one pixel per clock.
// Optional erase-before-redraw of each requester's previous rectangle: define DRAW_ARB_ERASE_EN.
// Handshake: a requester holds req high until its one-cycle done pulse; grant stays high
// for the whole service and inputs are sampled only on the grant edge.
module draw_port_arbiter
  import draw_pkg::*;
#(
  parameter int                  NUM_REQ   = 3,
  parameter int                  SPR_W     = 4,
  parameter int                  SPR_H     = 4,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [X_W*NUM_REQ-1:0]       req_x,
  input  logic [Y_W*NUM_REQ-1:0]       req_y,
  input  logic [COLOUR_W*NUM_REQ-1:0]  req_colour,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic                         busy,
  output logic [X_W-1:0]               x_out,
  output logic [Y_W-1:0]               y_out,
  output logic [COLOUR_W-1:0]          colour_out,
  output logic                         plot,
  output logic [1:0]                   dbg_state
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [3:0] COL_LAST = 4'(SPR_W-1);
  localparam logic [3:0] ROW_LAST = 4'(SPR_H-1);

  state_t                r_state;
  logic [PW-1:0]         r_ptr, r_win, w_win_idx;
  logic [NUM_REQ-1:0]    w_win_oh, r_grant, r_done;
  logic [X_W-1:0]        r_x0, r_cur_x, r_x, w_req_x, w_org_x;
  logic [Y_W-1:0]        r_y0, r_cur_y, r_y, w_req_y, w_org_y;
  logic [COLOUR_W-1:0]   r_c0, r_colour, w_req_c;
  logic [3:0]            r_col, r_row, w_ncol, w_nrow;
  logic                  r_plot, w_last, w_erase_first;
  pix_t                  w_first_pix, w_next_pix, w_draw_pix;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_win_oh)
  );

  always_comb begin
    w_win_idx = '0;
    w_req_x   = '0;
    w_req_y   = '0;
    w_req_c   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_win_oh[k]) begin
        w_win_idx = PW'(k);
        w_req_x   = req_x[X_W*k +: X_W];
        w_req_y   = req_y[Y_W*k +: Y_W];
        w_req_c   = req_colour[COLOUR_W*k +: COLOUR_W];
      end
    end
  end

`ifdef DRAW_ARB_ERASE_EN
  logic [X_W-1:0]     r_old_x [NUM_REQ];
  logic [Y_W-1:0]     r_old_y [NUM_REQ];
  logic [NUM_REQ-1:0] r_old_v;

  assign w_erase_first = r_old_v[w_win_idx];
  assign w_org_x       = w_erase_first ? r_old_x[w_win_idx] : w_req_x;
  assign w_org_y       = w_erase_first ? r_old_y[w_win_idx] : w_req_y;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_old_v <= '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        r_old_x[k] <= '0;
        r_old_y[k] <= '0;
      end
    end else if (r_state == S_DONE) begin
      r_old_x[r_win] <= r_x0;
      r_old_y[r_win] <= r_y0;
      r_old_v[r_win] <= 1'b1;
    end
  end
`else
  assign w_erase_first = 1'b0;
  assign w_org_x       = w_req_x;
  assign w_org_y       = w_req_y;
`endif

  // Column is the inner loop; r_col/r_row name the pixel currently on the outputs.
  assign w_last      = (r_col == COL_LAST) && (r_row == ROW_LAST);
  assign w_ncol      = (r_col == COL_LAST) ? 4'd0 : r_col + 4'd1;
  assign w_nrow      = (r_col == COL_LAST) ? r_row + 4'd1 : r_row;
  assign w_first_pix = make_pix(w_org_x, w_org_y, 4'd0, 4'd0);
  assign w_next_pix  = make_pix(r_cur_x, r_cur_y, w_ncol, w_nrow);
  assign w_draw_pix  = make_pix(r_x0, r_y0, 4'd0, 4'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_win    <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_x0     <= '0;
      r_y0     <= '0;
      r_c0     <= '0;
      r_cur_x  <= '0;
      r_cur_y  <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_plot   <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          r_plot <= 1'b0;
          if (|req) begin
            r_win    <= w_win_idx;
            r_grant  <= w_win_oh;
            r_x0     <= w_req_x;
            r_y0     <= w_req_y;
            r_c0     <= w_req_c;
            r_cur_x  <= w_org_x;
            r_cur_y  <= w_org_y;
            r_col    <= '0;
            r_row    <= '0;
            r_plot   <= w_first_pix.plot;
            r_x      <= w_first_pix.x;
            r_y      <= w_first_pix.y;
            r_colour <= w_erase_first ? BG_COLOUR : w_req_c;
            r_state  <= w_erase_first ? S_ERASE : S_DRAW;
          end
        end
        S_ERASE: begin
          if (w_last) begin
            r_cur_x  <= r_x0;
            r_cur_y  <= r_y0;
            r_col    <= '0;
            r_row    <= '0;
            r_plot   <= w_draw_pix.plot;
            r_x      <= w_draw_pix.x;
            r_y      <= w_draw_pix.y;
            r_colour <= r_c0;
            r_state  <= S_DRAW;
          end else begin
            r_col  <= w_ncol;
            r_row  <= w_nrow;
            r_plot <= w_next_pix.plot;
            r_x    <= w_next_pix.x;
            r_y    <= w_next_pix.y;
          end
        end
        S_DRAW: begin
          if (w_last) begin
            r_plot  <= 1'b0;
            r_grant <= '0;
            r_done  <= r_grant;
            r_state <= S_DONE;
          end else begin
            r_col  <= w_ncol;
            r_row  <= w_nrow;
            r_plot <= w_next_pix.plot;
            r_x    <= w_next_pix.x;
            r_y    <= w_next_pix.y;
          end
        end
        S_DONE: begin
          r_ptr   <= (r_win == PW'(NUM_REQ-1)) ? '0 : r_win + 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant      = r_grant;
  assign done       = r_done;
  assign busy       = (r_state != S_IDLE);
  assign x_out      = r_x;
  assign y_out      = r_y;
  assign colour_out = r_colour;
  assign plot       = r_plot;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_draw_port_arbiter.sv
// Self-checking bench for draw_port_arbiter (default build, 3 requesters, 4x4 sprites).
module tb_draw_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_colour;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic        busy;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour_out;
  logic        plot;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [17:0] exp_q[$];

  draw_port_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .plot       (plot),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req     = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic set_req_data(input int idx, input logic [7:0] x, input logic [6:0] y,
                              input logic [2:0] c);
    req_x[8*idx +: 8]      = x;
    req_y[7*idx +: 7]      = y;
    req_colour[3*idx +: 3] = c;
  endtask

  // One isolated service: scoreboard pixels, grant hold, plot count, done timing.
  task automatic serve(input int idx, input logic [7:0] x, input logic [6:0] y,
                       input logic [2:0] c, input int exp_plots, input string tag);
    int         done_cyc, plots, grant_bad, sx, sy;
    logic [2:0] oh;
    logic [7:0] px;
    logic [6:0] py;
    oh = '0;
    oh[idx] = 1'b1;
    exp_q.delete();
    for (int r = 0; r < 4; r++) begin
      for (int cc = 0; cc < 4; cc++) begin
        sx = int'(x) + cc;
        sy = int'(y) + r;
        if (sx < 160 && sy < 120) begin
          px = sx[7:0];
          py = sy[6:0];
          exp_q.push_back({px, py, c});
        end
      end
    end
    @(negedge clk);
    set_req_data(idx, x, y, c);
    req[idx]  = 1'b1;
    done_cyc  = -1;
    plots     = 0;
    grant_bad = 0;
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (cyc <= 16 && (grant !== oh || busy !== 1'b1)) grant_bad++;
      if (cyc == 17 && grant !== 3'b000) grant_bad++;
      if (plot === 1'b1) begin
        plots++;
        if (exp_q.size() == 0) check({tag, "_extra_pixel"}, {x_out, y_out, colour_out}, 32'hdead);
        else check({tag, "_pixel"}, {x_out, y_out, colour_out}, exp_q.pop_front());
      end
      if (done !== 3'b000) begin
        done_cyc = cyc;
        check({tag, "_done_vec"}, done, oh);
        req[idx] = 1'b0;
      end
    end
    check({tag, "_done_cycle"}, done_cyc, 17);
    check({tag, "_plots"}, plots, exp_plots);
    check({tag, "_missing_pixels"}, exp_q.size(), 0);
    check({tag, "_grant_hold"}, grant_bad, 0);
    @(negedge clk);
    check({tag, "_idle_after"}, {busy, done}, 4'b0000);
  endtask

  typedef struct {
    int         idx;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    int         plots;
    string      tag;
  } vec_t;

  vec_t vecs[7];
  int   order_exp[4];
  logic [2:0] order_got[4];
  int   n_gr, overlap, cyc_cnt, done_cyc;
  logic [2:0] prev_g;

  initial begin
    vecs[0] = '{1, 8'd10,  7'd20,  3'b100, 16, "single"};
    vecs[1] = '{0, 8'd158, 7'd118, 3'b011, 4,  "clip_corner"};
    vecs[2] = '{2, 8'd0,   7'd0,   3'b111, 16, "origin"};
    vecs[3] = '{0, 8'd159, 7'd0,   3'b001, 4,  "clip_right"};
    vecs[4] = '{1, 8'd200, 7'd10,  3'b010, 0,  "offscreen_x"};
    vecs[5] = '{2, 8'd157, 7'd119, 3'b110, 3,  "clip_both"};
    vecs[6] = '{0, 8'd255, 7'd127, 3'b101, 0,  "no_wrap"};
    order_exp = '{0, 1, 2, 0};

    reset_n    = 1'b0;
    req        = '0;
    req_x      = '0;
    req_y      = '0;
    req_colour = '0;
    repeat (3) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_plot", plot, 0);
    check("rst_xy", {x_out, y_out}, 0);
    check("rst_colour", colour_out, 0);
    check("rst_state", dbg_state, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++)
      serve(vecs[i].idx, vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].plots, vecs[i].tag);

    // Contention: all three held high from pointer 0.
    do_reset();
    set_req_data(0, 8'd1, 7'd1, 3'b001);
    set_req_data(1, 8'd2, 7'd2, 3'b010);
    set_req_data(2, 8'd3, 7'd3, 3'b011);
    req     = 3'b111;
    n_gr    = 0;
    overlap = 0;
    prev_g  = '0;
    order_got = '{3'b000, 3'b000, 3'b000, 3'b000};
    for (int cyc = 0; cyc < 200 && n_gr < 4; cyc++) begin
      @(negedge clk);
      if (!$onehot0(grant)) overlap++;
      if (grant !== 3'b000 && prev_g === 3'b000) begin
        order_got[n_gr] = grant;
        n_gr++;
      end
      prev_g = grant;
    end
    req = '0;
    for (int i = 0; i < 4; i++) check("rr_order", order_got[i], 32'(1) << order_exp[i]);
    check("rr_overlap", overlap, 0);

    // Pointer advance: after req0 is served, req0+req2 together go to 2.
    do_reset();
    serve(0, 8'd5, 7'd5, 3'b001, 16, "ptr_first");
    @(negedge clk);
    set_req_data(2, 8'd40, 7'd40, 3'b010);
    req = 3'b101;
    prev_g = '0;
    for (int cyc = 0; cyc < 10 && prev_g === 3'b000; cyc++) begin
      @(negedge clk);
      prev_g = grant;
    end
    check("ptr_advance", prev_g, 3'b100);
    req = '0;

    // Reset in the 5th DRAW cycle, then restart from pixel 0.
    do_reset();
    set_req_data(1, 8'd10, 7'd20, 3'b100);
    req[1] = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_pixel5", {plot, x_out, y_out}, {1'b1, 8'd10, 7'd21});
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_plot", plot, 0);
    check("mid_rst_grant", grant, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("restart_grant", grant, 3'b010);
    check("restart_pixel0", {plot, x_out, y_out, colour_out}, {1'b1, 8'd10, 7'd20, 3'b100});
    done_cyc = -1;
    cyc_cnt  = 1;
    for (int cyc = 2; cyc <= 40 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (done !== 3'b000) begin
        done_cyc = cyc;
        req = '0;
      end
    end
    check("restart_done_cycle", done_cyc, 17);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
